// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the 8-by-4 restoring divider:
//   - operand, quotient, remainder and counter widths
//   - the controller state enumeration (IDLE, RUN, DONE)
//   - the fixed results returned for a zero divisor
//   - a small helper used by the datapath to spot a zero divisor
// -----------------------------------------------------------------------------
package divider_pkg;

  // Operand widths: 8-bit dividend/quotient, 4-bit divisor/remainder.
  localparam int DVD_W = 8;
  localparam int DVS_W = 4;
  // Bit counter indexes dividend bits 7..0.
  localparam int CNT_W = 3;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The counter starts at the dividend MSB because quotient bits are
  // produced MSB first.
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(DVD_W - 1);

  // Results delivered when the captured divisor is zero.
  localparam logic [DVD_W-1:0] Q_DIV_ZERO = '1;
  localparam logic [DVS_W-1:0] R_DIV_ZERO = '0;

  // True when a divisor is zero.
  function automatic logic is_zero_divisor(input logic [DVS_W-1:0] dvs);
    return (dvs == '0);
  endfunction

endpackage

// File: rtl/div_step.sv
// -----------------------------------------------------------------------------
// div_step
// One combinational step of the restoring divider. It shifts the next
// dividend bit into the partial remainder, compares against the divisor in
// 5-bit arithmetic, and either subtracts (quotient bit 1) or keeps the shifted
// value (quotient bit 0).
//
// Ports
//   i_p        in   5  partial remainder P from the previous step (P[4] is 0)
//   i_bit      in   1  dividend bit being brought down this step
//   i_divisor  in   4  captured divisor
//   o_p        out  5  new partial remainder
//   o_q_bit    out  1  quotient bit produced by this step
// -----------------------------------------------------------------------------
module div_step
  import divider_pkg::*;
(
  input  logic [DVS_W:0]   i_p,
  input  logic             i_bit,
  input  logic [DVS_W-1:0] i_divisor,
  output logic [DVS_W:0]   o_p,
  output logic             o_q_bit
);

  logic [DVS_W:0] w_shifted;
  logic [DVS_W:0] w_divisor_ext;
  logic [DVS_W:0] w_diff;
  logic           w_ge;
  logic           w_zero;
  // P[4] is always zero after a step, so it is shifted out without being
  // looked at.
  logic           w_unused_p_msb;

  assign w_unused_p_msb = i_p[DVS_W];

  assign w_shifted     = {i_p[DVS_W-1:0], i_bit};
  assign w_divisor_ext = {1'b0, i_divisor};
  assign w_diff        = w_shifted - w_divisor_ext;
  assign w_ge          = (w_shifted >= w_divisor_ext);
  assign w_zero        = is_zero_divisor(i_divisor);

  always_comb begin
    o_p     = w_shifted;
    o_q_bit = 1'b0;
    if (w_zero) begin
      // With a zero divisor every compare succeeds, so each quotient bit is 1.
      // The partial remainder is held at zero so that P[4] stays clear and
      // the final remainder comes out as 0.
      o_p     = '0;
      o_q_bit = 1'b1;
    end else if (w_ge) begin
      o_p     = w_diff;
      o_q_bit = 1'b1;
    end
  end

endmodule

// File: rtl/divider_8by4.sv
// -----------------------------------------------------------------------------
// divider_8by4
// Sequential 8-bit by 4-bit unsigned restoring divider. It produces one
// quotient bit per clock, MSB first, and has a fixed latency: done pulses
// exactly 8 cycles after the edge that accepts start. The FSM, bit counter and
// all registers live here. The shift/compare/subtract step is in div_step.
//
// Ports
//   clk          in   1  clock, rising edge
//   rst          in   1  synchronous active-high reset
//   start        in   1  begin a division (looked at only in IDLE)
//   dividend     in   8  unsigned dividend, captured on accept
//   divisor      in   4  unsigned divisor, captured on accept
//   busy         out  1  high from accept until done drops
//   done         out  1  one-cycle pulse when results are valid
//   quotient     out  8  registered quotient
//   remainder    out  4  registered remainder
//   div_by_zero  out  1  captured divisor was zero (updated with done)
// -----------------------------------------------------------------------------
module divider_8by4
  import divider_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dividend,
  input  logic [DVS_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DVD_W-1:0] quotient,
  output logic [DVS_W-1:0] remainder,
  output logic             div_by_zero
);

  state_t           r_state;
  logic [DVD_W-1:0] r_dividend;
  logic [DVS_W-1:0] r_divisor;
  logic [CNT_W-1:0] r_count;
  logic [DVS_W:0]   r_p;
  // Quotient is built here so the visible quotient output stays unchanged
  // during RUN.
  logic [DVD_W-1:0] r_q_work;

  logic             r_busy;
  logic             r_done;
  logic [DVD_W-1:0] r_quotient;
  logic [DVS_W-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_bit;
  logic             w_q_bit;
  logic [DVS_W:0]   w_p_next;
  logic [DVD_W-1:0] w_q_next;

  assign w_bit = r_dividend[r_count];

  div_step u_step (
    .i_p       (r_p),
    .i_bit     (w_bit),
    .i_divisor (r_divisor),
    .o_p       (w_p_next),
    .o_q_bit   (w_q_bit)
  );

  // Working quotient with this step's bit merged in. On the last step this is
  // the full quotient that gets registered.
  always_comb begin
    w_q_next          = r_q_work;
    w_q_next[r_count] = w_q_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_dividend    <= '0;
      r_divisor     <= '0;
      r_count       <= '0;
      r_p           <= '0;
      r_q_work      <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= RUN;
            r_dividend <= dividend;
            r_divisor  <= divisor;
            r_count    <= CNT_START;
            r_p        <= '0;
            r_q_work   <= '0;
            r_busy     <= 1'b1;
          end
        end

        RUN: begin
          r_p      <= w_p_next;
          r_q_work <= w_q_next;
          if (r_count == '0) begin
            // The last step publishes all results together with done.
            r_quotient    <= w_q_next;
            r_remainder   <= w_p_next[DVS_W-1:0];
            r_div_by_zero <= is_zero_divisor(r_divisor);
            r_done        <= 1'b1;
            r_state       <= DONE;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end

        DONE: begin
          // Any start seen here is dropped. The next accept can only happen
          // from IDLE.
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end

        default: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_divider_8by4.sv
// -----------------------------------------------------------------------------
// tb_divider_8by4
// Self-checking bench for divider_8by4. A transaction-level model tracks the
// cycle count since the accept edge. It uses / and % to produce the expected
// results and compares the DUT outputs with it on every falling edge.
// Directed cases pin known results, and a shuffled sweep covers all 4096
// operand pairs with random disturbances.
// -----------------------------------------------------------------------------
module tb_divider_8by4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] dividend;
  logic [3:0] divisor;
  logic       busy;
  logic       done;
  logic [7:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  always #5 clk = ~clk;

  divider_8by4 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_active = 1'b0;
  int         m_cnt    = 0;
  logic [7:0] m_dvd;
  logic [3:0] m_dvs;
  logic       m_busy   = 1'b0;
  logic       m_done   = 1'b0;
  logic [7:0] m_q      = '0;
  logic [3:0] m_r      = '0;
  logic       m_dbz    = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_cnt    = 0;
      m_busy   = 1'b0;
      m_done   = 1'b0;
      m_q      = '0;
      m_r      = '0;
      m_dbz    = 1'b0;
    end else if (!m_active) begin
      m_done = 1'b0;
      if (start === 1'b1) begin
        m_active = 1'b1;
        m_cnt    = 0;
        m_dvd    = dividend;
        m_dvs    = divisor;
        m_busy   = 1'b1;
      end
    end else begin
      m_cnt++;
      if (m_cnt == 8) begin
        m_done = 1'b1;
        if (m_dvs == 4'd0) begin
          m_q   = 8'hFF;
          m_r   = 4'h0;
          m_dbz = 1'b1;
        end else begin
          m_q   = 8'(int'(m_dvd) / int'(m_dvs));
          m_r   = 4'(int'(m_dvd) % int'(m_dvs));
          m_dbz = 1'b0;
        end
      end else if (m_cnt == 9) begin
        m_active = 1'b0;
        m_busy   = 1'b0;
        m_done   = 1'b0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("done", 32'(done), 32'(m_done));
      check("quotient", 32'(quotient), 32'(m_q));
      check("remainder", 32'(remainder), 32'(m_r));
      check("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end
  end

  // One division: issue, optionally disturb the inputs during RUN and/or
  // pulse start during DONE, measure latency, and check the invariant.
  task automatic do_div(input logic [7:0] a, input logic [3:0] b,
                        input bit disturb, input bit poke_done,
                        output logic [7:0] q, output logic [3:0] r, output logic z);
    int w;
    int lat;
    w = 0;
    while (busy === 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("idle_before_start", 32'(busy), 32'd0);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 0;
    while (done !== 1'b1 && lat < 20) begin
      if (disturb) begin
        dividend = 8'($urandom);
        divisor  = 4'($urandom);
        start    = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    check("latency", 32'(lat), 32'd8);
    q = quotient;
    r = remainder;
    z = div_by_zero;
    if (b == 4'd0) begin
      check("dbz_quotient", 32'(q), 32'hFF);
      check("dbz_remainder", 32'(r), 32'h0);
      check("dbz_flag", 32'(z), 32'd1);
    end else begin
      check("invariant", 32'(int'(q) * int'(b) + int'(r)), 32'(a));
      check("rem_lt_div", 32'(r < b), 32'd1);
      check("dbz_clear", 32'(z), 32'd0);
    end
    if (poke_done) begin
      start    = 1'b1;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
    end
    @(negedge clk);
    start = 1'b0;
    $display("div %0d / %0d -> q=%0d r=%0d dbz=%0d lat=%0d", a, b, q, r, z, lat);
  endtask

  logic [11:0] pairs [4096];

  initial begin
    logic [7:0]  q;
    logic [3:0]  r;
    logic        z;
    logic [11:0] tmp;
    int          j;

    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    rst = 1'b0;

    do_div(8'd200, 4'd7, 1'b0, 1'b0, q, r, z);
    check("200/7 q", 32'(q), 32'd28);
    check("200/7 r", 32'(r), 32'd4);
    check("200/7 dbz", 32'(z), 32'd0);
    check("model 200/7 q", 32'(m_q), 32'd28);
    do_div(8'd255, 4'd1, 1'b0, 1'b0, q, r, z);
    check("255/1 q", 32'(q), 32'd255);
    check("255/1 r", 32'(r), 32'd0);
    do_div(8'd255, 4'd15, 1'b0, 1'b0, q, r, z);
    check("255/15 q", 32'(q), 32'd17);
    check("255/15 r", 32'(r), 32'd0);
    do_div(8'd0, 4'd5, 1'b0, 1'b0, q, r, z);
    check("0/5 q", 32'(q), 32'd0);
    check("0/5 r", 32'(r), 32'd0);
    do_div(8'd99, 4'd0, 1'b0, 1'b0, q, r, z);
    check("99/0 q", 32'(q), 32'hFF);
    check("99/0 r", 32'(r), 32'd0);
    check("99/0 dbz", 32'(z), 32'd1);
    check("model 99/0 dbz", 32'(m_dbz), 32'd1);

    // Ignored start/operand changes during RUN and a start pulse in DONE.
    do_div(8'd200, 4'd7, 1'b1, 1'b1, q, r, z);
    check("disturbed q", 32'(q), 32'd28);
    check("disturbed r", 32'(r), 32'd4);

    // Abort in mid-run, then an immediate new division.
    dividend = 8'd200; divisor = 4'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_quotient", 32'(quotient), 32'd0);
    check("abort_remainder", 32'(remainder), 32'd0);
    check("abort_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    do_div(8'd13, 4'd4, 1'b0, 1'b0, q, r, z);
    check("13/4 q", 32'(q), 32'd3);
    check("13/4 r", 32'(r), 32'd1);

    // Shuffled sweep of every operand pair.
    for (int i = 0; i < 4096; i++) pairs[i] = 12'(i);
    for (int i = 4095; i > 0; i--) begin
      j = int'($urandom_range(0, i));
      tmp = pairs[i]; pairs[i] = pairs[j]; pairs[j] = tmp;
    end
    for (int i = 0; i < 4096; i++) begin
      do_div(pairs[i][11:4], pairs[i][3:0], 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), q, r, z);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
